// File: rtl/uart_tx_frame_if.sv
// Request/line bundle between a byte producer and the UART transmitter.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  busy;

  // Producer side: issues requests, watches the line and busy flag.
  modport master (
    output P_DATA,
    output DATA_VALID,
    output PAR_EN,
    output PAR_TYP,
    input  TX_OUT,
    input  busy
  );

  // Transmitter side.
  modport slave (
    input  P_DATA,
    input  DATA_VALID,
    input  PAR_EN,
    input  PAR_TYP,
    output TX_OUT,
    output busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART frame serializer: start bit, data LSB first, optional parity, one stop bit.
// One CLK period is one bit time; TX_OUT and busy come straight from flops.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  uart_tx_frame_if.slave   tx_if
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_tx;
  logic                  r_busy;
  logic [CNT_W-1:0]      r_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_bit;
  logic                  r_par_en;

  state_t                w_state;
  logic                  w_tx;
  logic                  w_busy;
  logic [CNT_W-1:0]      w_cnt;
  logic [DATA_WIDTH-1:0] w_shift;
  logic                  w_par_bit;
  logic                  w_par_en;

  // Next state plus the line/busy values that become visible after the coming edge.
  always_comb begin
    w_state   = r_state;
    w_tx      = 1'b1;
    w_busy    = 1'b1;
    w_cnt     = r_cnt;
    w_shift   = r_shift;
    w_par_bit = r_par_bit;
    w_par_en  = r_par_en;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (tx_if.DATA_VALID) begin
          // Frame settings are captured here only; later input changes are ignored.
          w_state   = START;
          w_shift   = tx_if.P_DATA;
          w_par_en  = tx_if.PAR_EN;
          w_par_bit = (^tx_if.P_DATA) ^ tx_if.PAR_TYP;
          w_tx      = 1'b0;
          w_busy    = 1'b1;
        end
      end
      START: begin
        w_state = DATA;
        w_tx    = r_shift[0];
        w_shift = r_shift >> 1;
        w_cnt   = '0;
      end
      DATA: begin
        if (r_cnt == CNT_LAST) begin
          // Last data bit is on the line; counter returns to zero for the next frame.
          w_cnt = '0;
          if (r_par_en) begin
            w_state = PARITY;
            w_tx    = r_par_bit;
          end else begin
            w_state = STOP;
          end
        end else begin
          w_cnt   = r_cnt + CNT_W'(1);
          w_tx    = r_shift[0];
          w_shift = r_shift >> 1;
        end
      end
      PARITY: begin
        w_state = STOP;
      end
      STOP: begin
        // STOP always drains to IDLE, so a new request waits one idle-high bit.
        w_state = IDLE;
        w_busy  = 1'b0;
      end
      default: begin
        w_state = IDLE;
        w_busy  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any frame in flight.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_tx      <= w_tx;
      r_busy    <= w_busy;
      r_cnt     <= w_cnt;
      r_shift   <= w_shift;
      r_par_bit <= w_par_bit;
      r_par_en  <= w_par_en;
    end
  end

  assign tx_if.TX_OUT = r_tx;
  assign tx_if.busy   = r_busy;

endmodule
